fu_share_arbiter: RTL and testbench
===================================

Name: fu_share_arbiter

Overview:
- Shares one functional_unit instance, used in non-feedback mode, between NUM_REQ requesters.
- Each cycle a round-robin arbiter selects one valid requester and drives its operands and per-requester ALU opcode to the FU.
- A tag FIFO records the issue order so each FU result is returned to the requester that issued it.
- Sits between PE input routing and a shared FU, typically a multiplier.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the FU.
- NUM_REQ, 4, number of requesters; minimum 2.
- TAG_DEPTH, 4, outstanding-operation capacity of the tag FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_din_1  in  NUM_REQ*DATA_WIDTH  operand 1 per requester; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- req_din_2  in  NUM_REQ*DATA_WIDTH  operand 2 per requester.
- req_din_v  in  NUM_REQ  operand valid per requester.
- req_din_r  out  NUM_REQ  operand ready per requester.
- req_dout  out  NUM_REQ*DATA_WIDTH  result per requester.
- req_dout_v  out  NUM_REQ  result valid per requester.
- req_dout_r  in  NUM_REQ  result ready per requester.
- cfg_alu_sel  in  NUM_REQ*4  static ALU opcode per requester.
- fu_din_1, fu_din_2  out  DATA_WIDTH  FU operands.
- fu_din_v  out  1  FU operand valid.
- fu_din_r  in  1  FU operand ready.
- fu_alu_sel  out  4  FU opcode.
- fu_feedback  out  1  constant 0.
- fu_dout  in  DATA_WIDTH  FU result.
- fu_dout_v  in  1  FU result valid.
- fu_dout_r  out  1  FU result ready.
- busy  out  1  high while the tag FIFO is non-empty.
- err_orphan  out  1  sticky: fu_dout_v seen with an empty FIFO.

Behaviour:
- Reset (rst_n low at a clock edge):
  - rr_ptr=0; FIFO empty (rd_ptr=wr_ptr=0, count=0); err_orphan=0.
  - All outputs derive from this state: req_din_r=0, req_dout_v=0, fu_din_v=0, fu_dout_r=0, busy=0.
  - Reset mid-operation drops all outstanding tags; results arriving after reset count as orphans.
- Arbitration (combinational from state):
  - Requesters are searched starting at rr_ptr, ascending with wrap modulo NUM_REQ.
  - The first with req_din_v=1 is granted (gnt, index g).
  - No grant if no requester is valid or the FIFO is full (count==TAG_DEPTH).
- Issue path:
  - fu_din_v=1 only when granted.
  - fu_din_1, fu_din_2, fu_alu_sel = slice g; zero when there is no grant.
  - req_din_r[g] = fu_din_r when granted; all other req_din_r bits are 0.
  - Issue fires on fu_din_v && fu_din_r. On that edge: push g into the FIFO, rr_ptr <= (g+1) mod NUM_REQ.
  - On a stalled grant (fu_din_r=0), rr_ptr holds. The grant may move next cycle if the valid set changes, but a requester keeping req_din_v high is never starved: maximum wait is NUM_REQ-1 issues.
- Return path:
  - h = FIFO head tag.
  - When the FIFO is non-empty: req_dout_v[h] = fu_dout_v, req_dout[h] = fu_dout, fu_dout_r = req_dout_r[h].
  - Other req_dout_v bits are 0; other req_dout slices are 0.
  - Pop fires on fu_dout_v && fu_dout_r.
  - When the FIFO is empty: fu_dout_r=0, all req_dout_v=0. If fu_dout_v=1, set err_orphan (cleared only by reset).
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, issue is blocked combinationally even if a pop fires the same cycle; no bypass.
  - When empty, a same-cycle push does not enable pop; the head becomes valid the next cycle.
- Latency:
  - Arbiter adds zero cycles in both directions; end-to-end latency equals FU latency (1 cycle in non-feedback mode).
  - Result order per requester and globally is FIFO order.
- Widths: pointers are $clog2(TAG_DEPTH) bits and wrap naturally; count is $clog2(TAG_DEPTH)+1 bits; tags are $clog2(NUM_REQ) bits.
- Configuration: cfg_alu_sel is sampled only at issue and may change between operations without draining.

Test Plan:
- Single requester: after reset, req1 presents din_1=3, din_2=5, alu_sel=1 with all ready -> fu_din_v next edge accepted; 1 cycle later req_dout_v[1]=1, req_dout slice1=15, other dout_v=0.
- Round-robin: all 4 valid continuously, fu_din_r=1 -> grants in order 0,1,2,3,0,1; results return to requesters in the same order; each requester gets 1 issue per 4 cycles.
- Backpressure fill: req_dout_r=0 for all, req0 streams, TAG_DEPTH=4 -> exactly 4 issues accepted, then fu_din_v=0 and req_din_r=0; raising req_dout_r[0] drains results 1 per cycle in issue order with the operand values intact.
- Return stall: results for req2 then req0 queued, req_dout_r[2]=0 -> fu_dout_r=0 and req_dout_v[0] stays 0 until req2 is ready.
- Reset mid-operation: 3 tags outstanding, rst_n low 1 cycle -> busy=0, all valids 0, rr_ptr=0; a subsequent fu_dout_v=1 sets err_orphan=1, which stays high until the next reset.
- Grant stall: req1 and req3 valid, rr_ptr=1, fu_din_r=0 for 3 cycles -> grant held on req1, rr_ptr unchanged; fu_din_r=1 -> req1 issues and rr_ptr=2.

Source files
------------

// File: rtl/fu_share_arbiter.sv
// Purpose: lets NUM_REQ requesters share one functional unit (non-feedback mode), with round-robin issue and in-order result return through a tag FIFO.
// Latency: zero added cycles on both the issue and the return path; end-to-end latency equals the FU latency.
// Backpressure: issue stalls on fu_din_r low or a full tag FIFO; the return path passes the head owner's req_dout_r to fu_dout_r.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   req_din_1/2, req_din_v/r        per-requester operands, using valid/ready handshakes
//   req_dout, req_dout_v/r          per-requester results, using valid/ready handshakes
//   cfg_alu_sel                     static 4-bit opcode per requester, sampled at issue
//   fu_din_1/2, fu_din_v/r          operands sent to the shared FU
//   fu_alu_sel, fu_feedback         FU opcode; feedback mode is tied off
//   fu_dout, fu_dout_v/r            result returned by the shared FU
//   busy                            high while any operation is outstanding
//   err_orphan                      sticky flag: a result arrived while no operation was outstanding
module fu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din_2,
  input  logic [NUM_REQ-1:0]            req_din_v,
  output logic [NUM_REQ-1:0]            req_din_r,
  output logic [NUM_REQ*DATA_WIDTH-1:0] req_dout,
  output logic [NUM_REQ-1:0]            req_dout_v,
  input  logic [NUM_REQ-1:0]            req_dout_r,
  input  logic [NUM_REQ*4-1:0]          cfg_alu_sel,
  output logic [DATA_WIDTH-1:0]         fu_din_1,
  output logic [DATA_WIDTH-1:0]         fu_din_2,
  output logic                          fu_din_v,
  input  logic                          fu_din_r,
  output logic [3:0]                    fu_alu_sel,
  output logic                          fu_feedback,
  input  logic [DATA_WIDTH-1:0]         fu_dout,
  input  logic                          fu_dout_v,
  output logic                          fu_dout_r,
  output logic                          busy,
  output logic                          err_orphan
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic [TW-1:0] rr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tag_mem [TAG_DEPTH];

  logic          full;
  logic          empty;
  logic          gnt;
  logic [TW-1:0] gnt_idx;
  logic [TW-1:0] head;
  logic          push;
  logic          pop;
  int            srch;

  assign full        = (count == CW'(TAG_DEPTH));
  assign empty       = (count == '0);
  assign head        = tag_mem[rd_ptr];
  assign busy        = !empty;
  assign fu_feedback = 1'b0;

  // Round-robin search. It starts at rr_ptr and wraps modulo NUM_REQ, so a NUM_REQ value
  // that is not a power of two also works. A full FIFO blocks the grant even when a pop
  // happens in the same cycle.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    srch    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      srch = int'(rr_ptr) + k;
      if (srch >= NUM_REQ) srch = srch - NUM_REQ;
      if (!gnt && !full && req_din_v[TW'(srch)]) begin
        gnt     = 1'b1;
        gnt_idx = TW'(srch);
      end
    end
  end

  // Issue path: steer the granted requester's operands to the FU and return the FU's ready to that requester.
  always_comb begin
    fu_din_1   = '0;
    fu_din_2   = '0;
    fu_alu_sel = '0;
    req_din_r  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt && gnt_idx == TW'(i)) begin
        fu_din_1     = req_din_1[i*DATA_WIDTH +: DATA_WIDTH];
        fu_din_2     = req_din_2[i*DATA_WIDTH +: DATA_WIDTH];
        fu_alu_sel   = cfg_alu_sel[i*4 +: 4];
        req_din_r[i] = fu_din_r;
      end
    end
  end

  assign fu_din_v = gnt;
  assign push     = gnt & fu_din_r;

  // Return path: the FIFO head tag decides which requester sees the FU result.
  // With an empty FIFO the FU is never acknowledged.
  always_comb begin
    req_dout   = '0;
    req_dout_v = '0;
    fu_dout_r  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!empty && head == TW'(i)) begin
        req_dout_v[i]                         = fu_dout_v;
        req_dout[i*DATA_WIDTH +: DATA_WIDTH]  = fu_dout;
        fu_dout_r                             = req_dout_r[i];
      end
    end
  end

  assign pop = fu_dout_v & fu_dout_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rr_ptr <= (gnt_idx == TW'(NUM_REQ - 1)) ? '0 : gnt_idx + TW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (empty && fu_dout_v) err_orphan <= 1'b1;
    end
  end

  // Tag storage is not reset; only entries between the two pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_fu_share_arbiter.sv
module tb_fu_share_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TD = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*DW-1:0] req_din_1, req_din_2, req_dout;
  logic [NR-1:0]    req_din_v, req_din_r, req_dout_v, req_dout_r;
  logic [NR*4-1:0]  cfg_alu_sel;
  logic [DW-1:0]    fu_din_1, fu_din_2, fu_dout;
  logic             fu_din_v, fu_din_r, fu_feedback, fu_dout_v, fu_dout_r, busy, err_orphan;
  logic [3:0]       fu_alu_sel;

  // Behavioural FU with 1-cycle latency and a result queue; the inj_* signals force orphan results.
  logic [DW-1:0] fq [$];
  logic          fv_m = 1'b0;
  logic [DW-1:0] fd_m = '0;
  logic          inj_v;
  logic [DW-1:0] inj_dat;

  assign fu_dout_v = fv_m | inj_v;
  assign fu_dout   = inj_v ? inj_dat : fd_m;

  int checks = 0;
  int errors = 0;

  // Reference model: the round-robin pointer, the outstanding owners in issue order, and the expected results.
  int            m_rr;
  int            m_tag [$];
  logic [DW-1:0] m_res [$];
  logic          m_err;

  fu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_din_1(req_din_1), .req_din_2(req_din_2), .req_din_v(req_din_v), .req_din_r(req_din_r),
    .req_dout(req_dout), .req_dout_v(req_dout_v), .req_dout_r(req_dout_r),
    .cfg_alu_sel(cfg_alu_sel),
    .fu_din_1(fu_din_1), .fu_din_2(fu_din_2), .fu_din_v(fu_din_v), .fu_din_r(fu_din_r),
    .fu_alu_sel(fu_alu_sel), .fu_feedback(fu_feedback),
    .fu_dout(fu_dout), .fu_dout_v(fu_dout_v), .fu_dout_r(fu_dout_r),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fu_op(logic [3:0] sel, logic [DW-1:0] a, logic [DW-1:0] b);
    case (sel)
      4'd1:    return a * b;
      4'd2:    return a + b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
    end else begin
      if (fv_m && !inj_v && fu_dout_r && fq.size() > 0) void'(fq.pop_front());
      if (fu_din_v && fu_din_r) fq.push_back(fu_op(fu_alu_sel, fu_din_1, fu_din_2));
    end
    fv_m <= (fq.size() > 0);
    fd_m <= (fq.size() > 0) ? fq[0] : '0;
  end

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] sel);
    req_din_1[i*DW +: DW] = a;
    req_din_2[i*DW +: DW] = b;
    cfg_alu_sel[i*4 +: 4] = sel;
  endtask

  task automatic clear_inputs();
    req_din_1 = '0; req_din_2 = '0; req_din_v = '0; req_dout_r = '0;
    cfg_alu_sel = '0; fu_din_r = 1'b0; inj_v = 1'b0; inj_dat = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0; m_tag.delete(); m_res.delete(); m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (fu_din_v !== 1'b0) begin errors++; $display("FAIL reset_fu_din_v got %b exp 0", fu_din_v); end
    checks++; if (req_din_r !== '0) begin errors++; $display("FAIL reset_req_din_r got %b exp 0", req_din_r); end
    checks++; if (req_dout_v !== '0) begin errors++; $display("FAIL reset_req_dout_v got %b exp 0", req_dout_v); end
    checks++; if (fu_dout_r !== 1'b0) begin errors++; $display("FAIL reset_fu_dout_r got %b exp 0", fu_dout_r); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan got %b exp 0", err_orphan); end
    checks++; if (fu_feedback !== 1'b0) begin errors++; $display("FAIL reset_fu_feedback got %b exp 0", fu_feedback); end
    for (int i = 0; i < NR; i++) set_req(i, 32'(50 + i), 32'd1, 4'd2);
    req_din_v = '1;
    #1;
    checks++; if (fu_din_1 !== 32'd50) begin errors++; $display("FAIL reset_rr_start got %0d exp 50", fu_din_1); end
    req_din_v = '0;
  endtask

  task automatic test_single();
    logic [NR*DW-1:0] e;
    do_reset();
    req_dout_r = '1; fu_din_r = 1'b1;
    set_req(1, 32'd3, 32'd5, 4'd1);
    req_din_v = 4'b0010;
    #1;
    checks++; if (fu_din_v !== 1'b1) begin errors++; $display("FAIL single_fu_din_v got %b exp 1", fu_din_v); end
    checks++; if (req_din_r !== 4'b0010) begin errors++; $display("FAIL single_req_din_r got %b exp 0010", req_din_r); end
    checks++; if (fu_din_1 !== 32'd3 || fu_din_2 !== 32'd5) begin errors++; $display("FAIL single_operands got %0d,%0d exp 3,5", fu_din_1, fu_din_2); end
    checks++; if (fu_alu_sel !== 4'd1) begin errors++; $display("FAIL single_alu_sel got %0d exp 1", fu_alu_sel); end
    @(negedge clk);
    req_din_v = '0;
    #1;
    e = '0; e[DW +: DW] = 32'd15;
    checks++; if (req_dout_v !== 4'b0010) begin errors++; $display("FAIL single_dout_v got %b exp 0010", req_dout_v); end
    checks++; if (req_dout !== e) begin errors++; $display("FAIL single_dout got %h exp %h", req_dout, e); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || req_dout_v !== '0) begin errors++; $display("FAIL single_drained busy %b dout_v %b exp 0 0", busy, req_dout_v); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] e;
    do_reset();
    fu_din_r = 1'b1; req_dout_r = '1;
    for (int i = 0; i < NR; i++) set_req(i, 32'(i + 1), 32'd10, 4'd1);
    req_din_v = '1;
    for (int c = 0; c <= 8; c++) begin
      if (c == 8) req_din_v = '0;
      #1;
      if (c < 8) begin
        e = '0; e[c % NR] = 1'b1;
        checks++; if (req_din_r !== e) begin errors++; $display("FAIL rr_grant c%0d got %b exp %b", c, req_din_r, e); end
      end
      if (c > 0) begin
        e = '0; e[(c - 1) % NR] = 1'b1;
        checks++; if (req_dout_v !== e) begin errors++; $display("FAIL rr_return c%0d got %b exp %b", c, req_dout_v, e); end
        checks++; if (req_dout[((c - 1) % NR)*DW +: DW] !== 32'((((c - 1) % NR) + 1) * 10))
          begin errors++; $display("FAIL rr_value c%0d got %0d exp %0d", c, req_dout[((c - 1) % NR)*DW +: DW], (((c - 1) % NR) + 1) * 10); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fu_din_r = 1'b1; req_dout_r = '0;
    req_din_v = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      set_req(0, 32'(c + 1), 32'd2, 4'd1);
      #1;
      checks++; if (fu_din_v !== (c < TD)) begin errors++; $display("FAIL bp_fu_din_v c%0d got %b exp %b", c, fu_din_v, c < TD); end
      checks++; if (req_din_r !== ((c < TD) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL bp_req_din_r c%0d got %b", c, req_din_r); end
      @(negedge clk);
    end
    req_din_v = '0;
    req_dout_r = 4'b0001;
    for (int k = 0; k < TD; k++) begin
      #1;
      checks++; if (req_dout_v !== 4'b0001) begin errors++; $display("FAIL bp_drain_v k%0d got %b exp 0001", k, req_dout_v); end
      checks++; if (req_dout[0 +: DW] !== 32'((k + 1) * 2)) begin errors++; $display("FAIL bp_drain_val k%0d got %0d exp %0d", k, req_dout[0 +: DW], (k + 1) * 2); end
      @(negedge clk);
    end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_empty busy got %b exp 0", busy); end
  endtask

  task automatic test_return_stall();
    do_reset();
    fu_din_r = 1'b1; req_dout_r = 4'b0001;
    set_req(2, 32'd7, 32'd3, 4'd1);
    set_req(0, 32'd4, 32'd4, 4'd2);
    req_din_v = 4'b0100;
    @(negedge clk);
    req_din_v = 4'b0001;
    @(negedge clk);
    req_din_v = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (fu_dout_r !== 1'b0) begin errors++; $display("FAIL rs_fu_dout_r k%0d got %b exp 0", k, fu_dout_r); end
      checks++; if (req_dout_v !== 4'b0100) begin errors++; $display("FAIL rs_dout_v k%0d got %b exp 0100", k, req_dout_v); end
      @(negedge clk);
    end
    req_dout_r = 4'b0101;
    #1;
    checks++; if (fu_dout_r !== 1'b1 || req_dout[2*DW +: DW] !== 32'd21) begin errors++; $display("FAIL rs_release got r%b %0d exp r1 21", fu_dout_r, req_dout[2*DW +: DW]); end
    @(negedge clk);
    #1;
    checks++; if (req_dout_v !== 4'b0001 || req_dout[0 +: DW] !== 32'd8) begin errors++; $display("FAIL rs_second got %b %0d exp 0001 8", req_dout_v, req_dout[0 +: DW]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    fu_din_r = 1'b1; req_dout_r = '0;
    set_req(1, 32'd6, 32'd6, 4'd1);
    req_din_v = 4'b0010;
    repeat (3) @(negedge clk);
    req_din_v = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got %b exp 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || req_dout_v !== '0 || fu_dout_r !== 1'b0) begin errors++; $display("FAIL rm_after_reset busy %b dout_v %b fu_dout_r %b exp 0", busy, req_dout_v, fu_dout_r); end
    fu_din_r = 1'b0;
    set_req(0, 32'd100, 32'd1, 4'd2);
    req_din_v = '1;
    #1;
    checks++; if (fu_din_v !== 1'b1 || fu_din_1 !== 32'd100) begin errors++; $display("FAIL rm_rr_zero got v%b %0d exp v1 100", fu_din_v, fu_din_1); end
    req_din_v = '0;
    inj_v = 1'b1; inj_dat = 32'd9;
    #1;
    checks++; if (err_orphan !== 1'b0 || fu_dout_r !== 1'b0) begin errors++; $display("FAIL rm_pre_orphan err %b r %b exp 0 0", err_orphan, fu_dout_r); end
    @(negedge clk);
    inj_v = 1'b0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL rm_orphan_set got %b exp 1", err_orphan); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL rm_orphan_sticky got %b exp 1", err_orphan); end
    do_reset();
    #1;
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rm_orphan_clear got %b exp 0", err_orphan); end
  endtask

  task automatic test_grant_stall();
    do_reset();
    fu_din_r = 1'b1; req_dout_r = '1;
    set_req(0, 32'd1, 32'd1, 4'd1);
    req_din_v = 4'b0001;
    @(negedge clk);
    set_req(1, 32'd11, 32'd2, 4'd1);
    set_req(3, 32'd33, 32'd2, 4'd1);
    req_din_v = 4'b1010;
    fu_din_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (fu_din_v !== 1'b1 || req_din_r !== '0 || fu_din_1 !== 32'd11) begin errors++; $display("FAIL gs_hold k%0d v%b r%b %0d exp v1 r0000 11", k, fu_din_v, req_din_r, fu_din_1); end
      @(negedge clk);
    end
    fu_din_r = 1'b1;
    #1;
    checks++; if (req_din_r !== 4'b0010 || fu_din_1 !== 32'd11) begin errors++; $display("FAIL gs_issue r%b %0d exp 0010 11", req_din_r, fu_din_1); end
    @(negedge clk);
    #1;
    checks++; if (req_din_r !== 4'b1000 || fu_din_1 !== 32'd33) begin errors++; $display("FAIL gs_next r%b %0d exp 1000 33", req_din_r, fu_din_1); end
    @(negedge clk);
    req_din_v = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random(input int cycles);
    int            g, h, idx;
    logic [NR-1:0] e;
    logic          iss, pp, emp;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      req_din_v = 4'($urandom);
      for (int i = 0; i < NR; i++) set_req(i, $urandom, $urandom, 4'($urandom_range(0, 3)));
      fu_din_r   = ($urandom_range(0, 3) != 0);
      req_dout_r = 4'($urandom);
      #1;
      g = -1;
      if (m_tag.size() < TD)
        for (int k = 0; k < NR; k++) begin
          idx = (m_rr + k) % NR;
          if (g < 0 && req_din_v[idx]) g = idx;
        end
      e = '0;
      if (g >= 0 && fu_din_r) e[g] = 1'b1;
      checks++; if (fu_din_v !== (g >= 0)) begin errors++; $display("FAIL rnd_fu_din_v c%0d got %b exp %b", c, fu_din_v, g >= 0); end
      checks++; if (req_din_r !== e) begin errors++; $display("FAIL rnd_req_din_r c%0d got %b exp %b", c, req_din_r, e); end
      if (g >= 0) begin
        checks++; if (fu_din_1 !== req_din_1[g*DW +: DW] || fu_din_2 !== req_din_2[g*DW +: DW] || fu_alu_sel !== cfg_alu_sel[g*4 +: 4])
          begin errors++; $display("FAIL rnd_issue_data c%0d grant %0d got %h %h %0d", c, g, fu_din_1, fu_din_2, fu_alu_sel); end
      end
      emp = (m_tag.size() == 0);
      h = emp ? 0 : m_tag[0];
      e = '0;
      if (!emp && fu_dout_v) e[h] = 1'b1;
      checks++; if (req_dout_v !== e) begin errors++; $display("FAIL rnd_dout_v c%0d got %b exp %b", c, req_dout_v, e); end
      checks++; if (fu_dout_r !== (!emp && req_dout_r[h])) begin errors++; $display("FAIL rnd_fu_dout_r c%0d got %b exp %b", c, fu_dout_r, !emp && req_dout_r[h]); end
      if (!emp && fu_dout_v) begin
        checks++; if (req_dout[h*DW +: DW] !== m_res[0]) begin errors++; $display("FAIL rnd_result c%0d req %0d got %h exp %h", c, h, req_dout[h*DW +: DW], m_res[0]); end
      end
      checks++; if (busy !== !emp || err_orphan !== m_err) begin errors++; $display("FAIL rnd_status c%0d busy %b err %b exp %b %b", c, busy, err_orphan, !emp, m_err); end
      iss = (g >= 0) && fu_din_r;
      pp  = !emp && fu_dout_v && req_dout_r[h];
      if (emp && fu_dout_v) m_err = 1'b1;
      if (pp) begin void'(m_tag.pop_front()); void'(m_res.pop_front()); end
      if (iss) begin
        m_tag.push_back(g);
        m_res.push_back(fu_op(cfg_alu_sel[g*4 +: 4], req_din_1[g*DW +: DW], req_din_2[g*DW +: DW]));
        m_rr = (g + 1) % NR;
      end
      @(negedge clk);
    end
    clear_inputs();
    req_dout_r = '1;
    repeat (TD + 2) @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    m_rr = 0; m_err = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_return_stall();
    test_reset_mid();
    test_grant_stall();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
